// File: rtl/phase_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : phase_mem_arbiter
// Brief    : Shared-SRAM slot arbiter. Each mem_phi edge opens one slot, and
//            the slot goes to the CPU or the video fetch engine by phase.
//            Optional overrun flag is enabled by defining ARB_OVERRUN_DET_EN.
// Revision : 1.0  initial release
// ============================================================================
module phase_mem_arbiter #(
  parameter int                 ADDR_W   = 16,
  parameter int                 DATA_W   = 8,
  parameter int                 RD_LAT   = 1,
  parameter logic [ADDR_W-1:0]  VID_BASE = 'h0400,
  parameter int                 VID_LEN  = 960
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              cpu_phi,
  input  logic              mem_phi,
  input  logic              vid_phi,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              vid_sof,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef ARB_OVERRUN_DET_EN
  output logic              overrun,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] VID_LAST  = ADDR_W'(VID_BASE + VID_LEN - 1);
  localparam logic [1:0]        LAST_WAIT = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              mem_phi_q;
  logic              pend_q, pend_d;
  logic              pend_cpu_q, pend_cpu_d;
  logic              own_cpu_q, own_cpu_d;
  logic              we_q, we_d;
  logic [1:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] vid_ptr_q, vid_ptr_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              vid_valid_q, vid_valid_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;

  logic              slot_start;
  logic              svc_start;
  logic              svc_cpu;
  logic [ADDR_W-1:0] vid_addr;

  assign slot_start = (mem_phi != mem_phi_q);

  always_comb begin
    state_d     = state_q;
    pend_d      = 1'b0;
    pend_cpu_d  = pend_cpu_q;
    own_cpu_d   = own_cpu_q;
    we_d        = we_q;
    wait_cnt_d  = wait_cnt_q;
    vid_ptr_d   = vid_ptr_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    vid_valid_d = 1'b0;
    vid_data_d  = vid_data_q;
    svc_start   = 1'b0;
    svc_cpu     = 1'b0;
    vid_addr    = vid_sof ? VID_BASE : vid_ptr_q;

    if (vid_sof) begin
      vid_ptr_d = VID_BASE;
    end

    case (state_q)
      ST_IDLE: begin
        // An edge seen during DONE is serviced here with the owner it had then.
        svc_start = slot_start | pend_q;
        svc_cpu   = pend_q ? pend_cpu_q : cpu_phi;
        if (svc_start) begin
          if (svc_cpu) begin
            if (cpu_req) begin
              state_d     = ST_ACCESS;
              own_cpu_d   = 1'b1;
              we_d        = cpu_we;
              mem_req_d   = 1'b1;
              mem_we_d    = cpu_we;
              mem_addr_d  = cpu_addr;
              mem_wdata_d = cpu_wdata;
            end
          end else begin
            state_d    = ST_ACCESS;
            own_cpu_d  = 1'b0;
            we_d       = 1'b0;
            mem_req_d  = 1'b1;
            mem_addr_d = vid_addr;
            vid_ptr_d  = (vid_addr == VID_LAST) ? VID_BASE : vid_addr + ADDR_W'(1);
          end
        end
      end
      ST_ACCESS: begin
        state_d    = ST_WAIT;
        wait_cnt_d = 2'd0;
      end
      ST_WAIT: begin
        if (wait_cnt_q == LAST_WAIT) begin
          state_d = ST_DONE;
          if (own_cpu_q) begin
            cpu_ack_d = 1'b1;
            if (!we_q) begin
              cpu_rdata_d = mem_rdata;
            end
          end else begin
            vid_valid_d = 1'b1;
            vid_data_d  = mem_rdata;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        pend_d     = slot_start;
        pend_cpu_d = cpu_phi;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_phi_q   <= mem_phi;
      pend_q      <= 1'b0;
      pend_cpu_q  <= 1'b0;
      own_cpu_q   <= 1'b0;
      we_q        <= 1'b0;
      wait_cnt_q  <= 2'd0;
      vid_ptr_q   <= VID_BASE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_phi_q   <= mem_phi;
      pend_q      <= pend_d;
      pend_cpu_q  <= pend_cpu_d;
      own_cpu_q   <= own_cpu_d;
      we_q        <= we_d;
      wait_cnt_q  <= wait_cnt_d;
      vid_ptr_q   <= vid_ptr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_valid_q <= vid_valid_d;
      vid_data_q  <= vid_data_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign vid_data  = vid_data_q;
  assign vid_valid = vid_valid_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef ARB_OVERRUN_DET_EN
  logic overrun_q, overrun_d;

  // Sticky: a slot dropped while busy, or divider phases that disagree.
  always_comb begin
    overrun_d = overrun_q;
    if (slot_start && ((state_q == ST_ACCESS) || (state_q == ST_WAIT))) begin
      overrun_d = 1'b1;
    end
    if (slot_start && (vid_phi == cpu_phi)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  logic unused_vid_phi;
  assign unused_vid_phi = vid_phi;
`endif

endmodule
`default_nettype wire
